tpu_cmd_sequencer: RTL and testbench
====================================

# tpu_cmd_sequencer

Upstream command front-end for the systolic matmul wrapper. It buffers matmul commands (W/X/OUT base addresses plus a tag) in a small FIFO and issues them one at a time to the wrapper's `start`/`base_addr_*` interface. It waits for the wrapper's `done` pulse, then returns a tagged completion record to the host through a valid/ready handshake.

## Interface
- `ADDRESS_WIDTH`, 13: width of every base address; matches the wrapper.
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TAG_WIDTH`, 4: opaque command tag, returned unchanged in the completion.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host offers a command.
- `cmd_ready`  out  1  equals `!full`, driven only from registered FIFO count.
- `cmd_base_w`, `cmd_base_x`, `cmd_base_out`  in  ADDRESS_WIDTH each  command addresses.
- `cmd_tag`  in  TAG_WIDTH  command tag.
- `start`  out  1  one-cycle pulse to the wrapper.
- `base_addr_w`, `base_addr_x`, `base_addr_out`  out  ADDRESS_WIDTH each  registered addresses; held stable from the `start` cycle until the next issue.
- `done`  in  1  wrapper completion pulse.
- `cpl_valid`  out  1  completion record available.
- `cpl_ready`  in  1  host accepts the completion.
- `cpl_tag`  out  TAG_WIDTH  tag of the completed command.
- `cpl_cycles`  out  32  cycles spent in execution (see Configuration).
- `busy`  out  1  high when FSM is not IDLE, or FIFO is non-empty, or `cpl_valid` is high.
- `queue_level`  out  $clog2(DEPTH)+1  registered FIFO occupancy.

## Operation
- FIFO: push on `cmd_valid && cmd_ready`. Pop only in the ISSUE transition.
  - When full, a pop in the same cycle does not raise `cmd_ready` that cycle; the slot becomes visible the next cycle.
  - Push and pop in the same cycle leave `queue_level` unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if the FIFO is non-empty and `cpl_valid` is 0, go to ISSUE.
  - ISSUE (one cycle): register `start`=1 and the head addresses to `base_addr_*`, latch the head tag internally, pop the FIFO, clear the cycle counter to 1, go to WAIT.
  - WAIT: increment the cycle counter each cycle. On `done`=1: load `cpl_tag` and `cpl_cycles` (counter value including the done cycle), set `cpl_valid`, go to IDLE.
- `done` seen in IDLE or ISSUE is ignored.
- A new issue is blocked while `cpl_valid` is high. Only one command is ever in flight; `start` is never asserted while the wrapper is running.
- `cpl_valid` clears on `cpl_ready && cpl_valid`. `cpl_tag` and `cpl_cycles` are stable while `cpl_valid` is high.
- Cycle counter saturates at 2^32-1 and never wraps.

## Timing
- Reset values:
  - `cmd_ready`=1, `start`=0, `base_addr_*`=0, `cpl_valid`=0, `cpl_tag`=0, `cpl_cycles`=0, `busy`=0, `queue_level`=0.
  - FSM=IDLE, FIFO empty.
- Command accepted on edge k into an idle, empty block: `start` is high for exactly the cycle following edge k+2 (IDLE→ISSUE at k+1, outputs registered at k+2), and `base_addr_*` are valid in that same cycle.
- `done` sampled high at edge d: `cpl_valid` is high from edge d. The earliest next `start` follows `cpl` acceptance at edge a, at edge a+2.
- Reset asserted mid-operation (any state): immediate return to reset values. Queued commands and any pending completion are discarded. The wrapper must be reset concurrently.

## Configuration
- `TPU_CMD_SEQ_PERF_EN` defined: the 32-bit cycle counter is built and `cpl_cycles` reports execution cycles as above.
- Not defined: no counter is synthesized, and `cpl_cycles` is tied to 0. All other behaviour is identical.

## Test plan
- Single command (W=0x100, X=0x200, OUT=0x300, tag=5); `done` asserted 40 cycles after `start` → exactly one `start` pulse with those addresses; `cpl_tag`=5; `cpl_cycles`=41 with PERF on, 0 with PERF off.
- Push 5 commands back-to-back with `done` withheld → `cmd_ready` drops after 4 are accepted (one popped by ISSUE reopens a slot one cycle later); `queue_level` tracks occupancy; tags complete in order 0,1,2,3,4.
- Hold `cpl_ready`=0 for 20 cycles after the first completion → `cpl_valid`, `cpl_tag` and `cpl_cycles` are stable and no second `start` occurs. Release → next `start` follows 2 cycles after the handshake.
- Pulse `done` while in IDLE with an empty FIFO → no `cpl_valid`, no state change.
- Assert `rst_n`=0 during WAIT with 3 commands queued → all outputs return to reset values. After release no `start` occurs until a new command is pushed.
- Cycle counter forced near saturation (long `done` delay in a reduced-width debug run or forced value) → `cpl_cycles` saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/tpu_cmd_sequencer_if.sv
// Signal bundle between the command sequencer, its host and the matmul wrapper.
// slave is the sequencer's own view; master is the host/wrapper side.
// Widths follow the same parameters as the sequencer and must match its instance.
interface tpu_cmd_sequencer_if #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DEPTH         = 4,
    parameter int TAG_WIDTH     = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // host command channel
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDRESS_WIDTH-1:0] cmd_base_w;
    logic [ADDRESS_WIDTH-1:0] cmd_base_x;
    logic [ADDRESS_WIDTH-1:0] cmd_base_out;
    logic [TAG_WIDTH-1:0]     cmd_tag;
    // wrapper control
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] base_addr_w;
    logic [ADDRESS_WIDTH-1:0] base_addr_x;
    logic [ADDRESS_WIDTH-1:0] base_addr_out;
    logic                     done;
    // completion channel and status
    logic                     cpl_valid;
    logic                     cpl_ready;
    logic [TAG_WIDTH-1:0]     cpl_tag;
    logic [31:0]              cpl_cycles;
    logic                     busy;
    logic [LVL_W-1:0]         queue_level;

    modport slave (
        input  cmd_valid, cmd_base_w, cmd_base_x, cmd_base_out, cmd_tag,
        input  done, cpl_ready,
        output cmd_ready, start, base_addr_w, base_addr_x, base_addr_out,
        output cpl_valid, cpl_tag, cpl_cycles, busy, queue_level
    );

    modport master (
        output cmd_valid, cmd_base_w, cmd_base_x, cmd_base_out, cmd_tag,
        output done, cpl_ready,
        input  cmd_ready, start, base_addr_w, base_addr_x, base_addr_out,
        input  cpl_valid, cpl_tag, cpl_cycles, busy, queue_level
    );
endinterface

// File: rtl/tpu_cmd_sequencer.sv
// Purpose: queue matmul commands and issue them one at a time to the wrapper, returning tagged completions.
// Latency: command accepted at edge k -> start registered at edge k+2; done at edge d -> cpl_valid from edge d.
// Backpressure: cmd_ready = !full from the registered count; a pending completion blocks further issues.
// Optional build macro TPU_CMD_SEQ_PERF_EN adds the 32-bit saturating execution cycle counter.
module tpu_cmd_sequencer #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DEPTH         = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    tpu_cmd_sequencer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] w;
        logic [ADDRESS_WIDTH-1:0] x;
        logic [ADDRESS_WIDTH-1:0] o;
        logic [TAG_WIDTH-1:0]     tag;
    } cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    cmd_t                     mem_q [DEPTH];
    cmd_t                     cmd_in;
    cmd_t                     head;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]         count_q, count_d;
    state_t                   state_q, state_d;
    logic                     start_q, start_d;
    logic [ADDRESS_WIDTH-1:0] base_w_q, base_w_d, base_x_q, base_x_d, base_o_q, base_o_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [TAG_WIDTH-1:0]     cpl_tag_q, cpl_tag_d;
    logic                     cpl_valid_q, cpl_valid_d;
    logic                     cmd_ready;
    logic                     push, pop;
`ifdef TPU_CMD_SEQ_PERF_EN
    logic [31:0]              cyc_q, cyc_d;
    logic [31:0]              cpl_cycles_q, cpl_cycles_d;
`endif

    assign cmd_in    = '{w: bus.cmd_base_w, x: bus.cmd_base_x, o: bus.cmd_base_out, tag: bus.cmd_tag};
    assign head      = mem_q[rd_ptr_q];
    // Ready is derived purely from the registered count, so a pop cannot reopen a full FIFO in the same cycle.
    assign cmd_ready = (count_q != LVL_W'(DEPTH));
    assign push      = bus.cmd_valid && cmd_ready;
    // Only the ISSUE state consumes; it is entered only with a non-empty FIFO.
    assign pop       = (state_q == ST_ISSUE);

    // Next-state logic for the FIFO pointers, issue FSM and completion record.
    always_comb begin
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - LVL_W'(1);
        end
        state_d     = state_q;
        start_d     = 1'b0;
        base_w_d    = base_w_q;
        base_x_d    = base_x_q;
        base_o_d    = base_o_q;
        tag_d       = tag_q;
        cpl_tag_d   = cpl_tag_q;
        cpl_valid_d = cpl_valid_q && !bus.cpl_ready;
`ifdef TPU_CMD_SEQ_PERF_EN
        cyc_d        = cyc_q;
        cpl_cycles_d = cpl_cycles_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // An unaccepted completion holds off the next issue.
                if ((count_q != '0) && !cpl_valid_q) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_d  = 1'b1;
                base_w_d = head.w;
                base_x_d = head.x;
                base_o_d = head.o;
                tag_d    = head.tag;
`ifdef TPU_CMD_SEQ_PERF_EN
                cyc_d    = 32'd1;
`endif
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef TPU_CMD_SEQ_PERF_EN
                cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
`endif
                if (bus.done) begin
                    cpl_tag_d    = tag_q;
`ifdef TPU_CMD_SEQ_PERF_EN
                    // The reported count includes the done cycle itself.
                    cpl_cycles_d = cyc_q;
`endif
                    cpl_valid_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers; reset discards queued commands and any pending completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            base_w_q     <= '0;
            base_x_q     <= '0;
            base_o_q     <= '0;
            tag_q        <= '0;
            cpl_tag_q    <= '0;
            cpl_valid_q  <= 1'b0;
`ifdef TPU_CMD_SEQ_PERF_EN
            cyc_q        <= '0;
            cpl_cycles_q <= '0;
`endif
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            start_q      <= start_d;
            base_w_q     <= base_w_d;
            base_x_q     <= base_x_d;
            base_o_q     <= base_o_d;
            tag_q        <= tag_d;
            cpl_tag_q    <= cpl_tag_d;
            cpl_valid_q  <= cpl_valid_d;
`ifdef TPU_CMD_SEQ_PERF_EN
            cyc_q        <= cyc_d;
            cpl_cycles_q <= cpl_cycles_d;
`endif
        end
    end

    // Command storage; entries are only read after being written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    assign bus.cmd_ready     = cmd_ready;
    assign bus.start         = start_q;
    assign bus.base_addr_w   = base_w_q;
    assign bus.base_addr_x   = base_x_q;
    assign bus.base_addr_out = base_o_q;
    assign bus.cpl_valid     = cpl_valid_q;
    assign bus.cpl_tag       = cpl_tag_q;
`ifdef TPU_CMD_SEQ_PERF_EN
    assign bus.cpl_cycles    = cpl_cycles_q;
`else
    assign bus.cpl_cycles    = 32'd0;
`endif
    assign bus.busy          = (state_q != ST_IDLE) || (count_q != '0) || cpl_valid_q;
    assign bus.queue_level   = count_q;
endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_tpu_cmd_sequencer;
    localparam int AW = 13;
    localparam int DEPTH = 4;
    localparam int TW = 4;
`ifdef TPU_CMD_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tpu_cmd_sequencer_if #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) bus();
    tpu_cmd_sequencer #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic [AW-1:0] w; logic [AW-1:0] x; logic [AW-1:0] o; logic [TW-1:0] tag; } cmd_t;
    typedef struct { logic [TW-1:0] tag; logic [31:0] cycles; } cpl_t;

    cmd_t exp_cmd_q[$];   // commands accepted, in the order they must be issued
    cpl_t exp_cpl_q[$];   // completions the host must see, in order
    int   checks = 0;
    int   failures = 0;

    // wrapper model state
    bit   wr_busy = 0;
    int   wr_cnt = 0;
    int   wr_lat = 0;
    logic [TW-1:0] wr_tag = '0;
    int   start_count = 0;
    int   fixed_lat = 0;
    bit   inject_done = 0;
    bit   sat_expect = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({pfx, "_start"}, bus.start, 0);
        chk({pfx, "_base_w"}, bus.base_addr_w, 0);
        chk({pfx, "_base_x"}, bus.base_addr_x, 0);
        chk({pfx, "_base_out"}, bus.base_addr_out, 0);
        chk({pfx, "_cpl_valid"}, bus.cpl_valid, 0);
        chk({pfx, "_cpl_tag"}, bus.cpl_tag, 0);
        chk({pfx, "_cpl_cycles"}, bus.cpl_cycles, 0);
        chk({pfx, "_busy"}, bus.busy, 0);
        chk({pfx, "_queue_level"}, bus.queue_level, 0);
    endtask

    // Offer one command; returns #1 after the edge that accepted it.
    task automatic send_cmd(input logic [AW-1:0] w, input logic [AW-1:0] x,
                            input logic [AW-1:0] o, input logic [TW-1:0] tag);
        cmd_t c;
        bit   ok = 0;
        c.w = w; c.x = x; c.o = o; c.tag = tag;
        bus.cmd_valid = 1'b1;
        bus.cmd_base_w = w; bus.cmd_base_x = x; bus.cmd_base_out = o; bus.cmd_tag = tag;
        for (int i = 0; i < 1000; i++) begin
            if (bus.cmd_ready) begin
                exp_cmd_q.push_back(c);
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        if (!ok) timeout_fail("send_cmd");
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy && !wr_busy && exp_cmd_q.size() == 0 && exp_cpl_q.size() == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) timeout_fail("wait_idle");
    endtask

    // Wrapper model: checks every start against the queued command and answers with done after its latency.
    initial begin : wrapper_model
        cmd_t c;
        cpl_t e;
        bus.done = 1'b0;
        forever begin
            tick();
            if (!rst_n) begin
                wr_busy = 0;
                bus.done = 1'b0;
                continue;
            end
            bus.done = inject_done;
            if (bus.start) begin
                start_count++;
                chk("start_while_running", wr_busy, 0);
                if (exp_cmd_q.size() == 0) begin
                    timeout_fail("start_without_command");
                end else begin
                    c = exp_cmd_q.pop_front();
                    chk("issue_base_w", bus.base_addr_w, c.w);
                    chk("issue_base_x", bus.base_addr_x, c.x);
                    chk("issue_base_out", bus.base_addr_out, c.o);
                    wr_tag = c.tag;
                end
                wr_busy = 1;
                wr_cnt = 1;
                wr_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 12));
            end else if (wr_busy) begin
                wr_cnt++;
            end
            // wr_cnt counts the start cycle through the current cycle inclusive
            if (wr_busy && wr_cnt == wr_lat + 1) begin
                bus.done = 1'b1;
                e.tag = wr_tag;
                e.cycles = sat_expect ? 32'hFFFF_FFFF : (PERF ? 32'(wr_cnt) : 32'd0);
                exp_cpl_q.push_back(e);
                wr_busy = 0;
            end
        end
    end

    // Completion monitor: whenever a record is presented it must equal the oldest expected one.
    initial begin : cpl_monitor
        cpl_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (bus.cpl_valid) begin
                chk("busy_with_cpl", bus.busy, 1);
                if (exp_cpl_q.size() == 0) begin
                    timeout_fail("unexpected_completion");
                end else begin
                    e = exp_cpl_q[0];
                    chk("cpl_tag", bus.cpl_tag, e.tag);
                    chk("cpl_cycles", bus.cpl_cycles, e.cycles);
                    if (bus.cpl_ready) void'(exp_cpl_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0;
        int acc;
        bit ok;
        bus.cmd_valid = 1'b0;
        bus.cmd_base_w = '0; bus.cmd_base_x = '0; bus.cmd_base_out = '0; bus.cmd_tag = '0;
        bus.cpl_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_reset");

        // single command, latency 40, start timing
        fixed_lat = 40;
        s0 = start_count;
        send_cmd(13'h100, 13'h200, 13'h300, 4'd5);
        chk("t1_level_k", bus.queue_level, 1);
        chk("t1_start_k", bus.start, 0);
        chk("t1_busy_k", bus.busy, 1);
        tick();
        chk("t1_start_k1", bus.start, 0);
        chk("t1_level_k1", bus.queue_level, 1);
        tick();
        chk("t1_start_k2", bus.start, 1);
        chk("t1_level_k2", bus.queue_level, 0);
        chk("t1_base_w", bus.base_addr_w, 13'h100);
        chk("t1_base_x", bus.base_addr_x, 13'h200);
        chk("t1_base_out", bus.base_addr_out, 13'h300);
        tick();
        chk("t1_start_k3", bus.start, 0);
        chk("t1_base_w_held", bus.base_addr_w, 13'h100);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.cpl_valid) begin ok = 1; break; end
            tick();
        end
        if (!ok) timeout_fail("t1_cpl_wait");
        chk("t1_one_start", start_count - s0, 1);

        // completion held 20 cycles while 5 commands are offered back-to-back
        fixed_lat = 0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_base_w = 13'h400 + AW'(acc);
            bus.cmd_base_x = 13'h800 + AW'(acc);
            bus.cmd_base_out = 13'h1000 + AW'(acc);
            bus.cmd_tag = TW'(acc);
            chk("hold_cpl_valid", bus.cpl_valid, 1);
            chk("hold_level", bus.queue_level, acc);
            chk("hold_ready", bus.cmd_ready, acc < 4);
            chk("hold_no_start", bus.start, 0);
            if (bus.cmd_ready && acc < 5) begin
                exp_cmd_q.push_back('{w: bus.cmd_base_w, x: bus.cmd_base_x, o: bus.cmd_base_out, tag: bus.cmd_tag});
                acc++;
            end
            tick();
        end
        chk("hold_start_count", start_count - s0, 1);
        bus.cpl_ready = 1'b1;
        tick();
        chk("rel_a0_cpl_valid", bus.cpl_valid, 0);
        chk("rel_a0_start", bus.start, 0);
        chk("rel_a0_ready", bus.cmd_ready, 0);
        tick();
        chk("rel_a1_start", bus.start, 0);
        chk("rel_a1_level", bus.queue_level, 4);
        chk("rel_a1_ready", bus.cmd_ready, 0);
        tick();
        chk("rel_a2_start", bus.start, 1);
        chk("rel_a2_level", bus.queue_level, 3);
        chk("rel_a2_ready", bus.cmd_ready, 1);
        if (bus.cmd_ready) begin
            exp_cmd_q.push_back('{w: bus.cmd_base_w, x: bus.cmd_base_x, o: bus.cmd_base_out, tag: bus.cmd_tag});
            acc++;
        end
        tick();
        bus.cmd_valid = 1'b0;
        chk("rel_a3_level", bus.queue_level, 4);
        chk("rel_a3_ready", bus.cmd_ready, 0);
        chk("rel_accepted", acc, 5);
        wait_idle(500);

        // done pulse while idle and empty is ignored
        @(negedge clk);
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_done_cpl_valid", bus.cpl_valid, 0);
            chk("idle_done_busy", bus.busy, 0);
            chk("idle_done_start", bus.start, 0);
        end
        tick();

        // reset during WAIT with three commands queued
        fixed_lat = 50;
        for (int i = 0; i < 4; i++) send_cmd(13'h20 + AW'(i), 13'h40 + AW'(i), 13'h60 + AW'(i), TW'(8 + i));
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_busy && bus.queue_level == 3) begin ok = 1; break; end
            tick();
        end
        if (!ok) timeout_fail("rst_setup");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_cmd_q.delete();
        exp_cpl_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        s0 = start_count;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("postrst_start", bus.start, 0);
            chk("postrst_busy", bus.busy, 0);
            chk("postrst_level", bus.queue_level, 0);
        end
        chk("postrst_start_count", start_count - s0, 0);
        fixed_lat = 3;
        send_cmd(13'h1AB, 13'h0CD, 13'h0EF, 4'd9);
        wait_idle(200);

        // randomized traffic with random completion backpressure
        fixed_lat = 0;
        begin
            bit snd_done = 0;
            fork
                begin
                    for (int n = 0; n < 40; n++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send_cmd(AW'($urandom), AW'($urandom), AW'($urandom), TW'($urandom));
                    end
                    snd_done = 1;
                end
                begin
                    while (!snd_done) begin
                        bus.cpl_ready = ($urandom_range(0, 3) != 0);
                        tick();
                    end
                end
            join
        end
        bus.cpl_ready = 1'b1;
        wait_idle(2000);

`ifdef TPU_CMD_SEQ_PERF_EN
        // counter pushed near its limit saturates instead of wrapping
        fixed_lat = 40;
        sat_expect = 1;
        send_cmd(13'h111, 13'h222, 13'h333, 4'd7);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_busy && wr_cnt >= 3) begin ok = 1; break; end
            tick();
        end
        if (!ok) timeout_fail("sat_setup");
        @(negedge clk);
        force dut.cyc_q = 32'hFFFF_FFF0;
        @(negedge clk);
        release dut.cyc_q;
        wait_idle(200);
        sat_expect = 0;
`endif

        chk("end_cmd_queue_empty", exp_cmd_q.size(), 0);
        chk("end_cpl_queue_empty", exp_cpl_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
